// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for fp_mul_pipe
//
// Purpose: groups the valid/ready operand input channel and the
//          valid/ready result output channel of the multiplier.
// Signals:
//   in_valid  operand pair valid         (master -> slave)
//   in_ready  slave accepts operands     (slave  -> master)
//   op1, op2  packed {sign, exp, frac}   (master -> slave)
//   out_valid result valid               (slave  -> master)
//   out_ready master accepts result      (master -> slave)
//   result    packed product             (slave  -> master)
//   flags     {invalid, overflow, underflow, inexact} (slave -> master)
interface fp_mul_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - pipelined flush-to-zero floating-point multiplier
//
// Purpose: multiplies two packed floating-point operands with
//          round-to-nearest-even, flush-to-zero for exp == 0 inputs,
//          and IEEE-style special-case handling, in a STAGES-deep
//          pipeline with a single global advance enable.
// Parameters:
//   EXP_WIDTH   exponent field width
//   FRAC_WIDTH  stored fraction width (W = 1 + EXP_WIDTH + FRAC_WIDTH)
//   STAGES      pipeline depth in registers, 2..4
// Ports:
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  fp_mul_pipe_if slave modport (operands in, result/flags out)
module fp_mul_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7,
  parameter int STAGES     = 3
) (
  input logic          clk,
  input logic          rst,
  fp_mul_pipe_if.slave bus
);
  localparam int E  = EXP_WIDTH;
  localparam int F  = FRAC_WIDTH;
  localparam int W  = 1 + E + F;
  localparam int P  = 2 * (F + 1);
  localparam int XW = E + 2;

  localparam logic [XW-1:0] BIAS    = XW'((1 << (E - 1)) - 1);
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << E) - 1);
  localparam logic [W-1:0]  QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(F - 1){1'b0}}};

  // Global advance enable: the whole pipe moves or the whole pipe holds.
  logic en;
  logic out_v;

  // Stage 1 decode (combinational from the operands)
  logic         sa, sb;
  logic [E-1:0] e1, e2;
  logic [F-1:0] f1, f2;
  logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic         sign_d;
  logic         spec_d;
  logic         spec_inv_d;
  logic [W-1:0] spec_res_d;
  logic [XW-1:0] exp_d;
  logic [P-1:0]  prod_d;

  assign {sa, e1, f1} = bus.op1;
  assign {sb, e2, f2} = bus.op2;

  assign nan_a  = (&e1) && (|f1);
  assign nan_b  = (&e2) && (|f2);
  assign inf_a  = (&e1) && !(|f1);
  assign inf_b  = (&e2) && !(|f2);
  // exp == 0 covers both true zero and subnormals (flushed)
  assign zero_a = ~|e1;
  assign zero_b = ~|e2;
  assign sign_d = sa ^ sb;

  always_comb begin
    spec_d     = 1'b0;
    spec_inv_d = 1'b0;
    spec_res_d = '0;
    if (nan_a || nan_b) begin
      spec_d     = 1'b1;
      spec_res_d = QNAN;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      spec_d     = 1'b1;
      spec_inv_d = 1'b1;
      spec_res_d = QNAN;
    end else if (inf_a || inf_b) begin
      spec_d     = 1'b1;
      spec_res_d = {sign_d, {E{1'b1}}, {F{1'b0}}};
    end else if (zero_a || zero_b) begin
      spec_d     = 1'b1;
      spec_res_d = {sign_d, {(W - 1){1'b0}}};
    end
  end

  // Unsigned arithmetic in XW bits; MSB acts as the sign of the biased sum.
  assign exp_d  = {2'b00, e1} + {2'b00, e2} - BIAS;
  assign prod_d = P'({1'b1, f1}) * P'({1'b1, f2});

  // Stage 1 registers
  logic          s1_sign;
  logic          s1_spec;
  logic          s1_spec_inv;
  logic [W-1:0]  s1_spec_res;
  logic [XW-1:0] s1_exp;
  logic [P-1:0]  s1_prod;

  // Normalise / round (combinational from stage 1)
  logic [P-2:0]  norm;
  logic [F-1:0]  frac_n;
  logic          guard, sticky, round_up;
  logic [F:0]    frac_r;
  logic [XW-1:0] exp_f;
  logic          ovf, udf;
  logic [W-1:0]  res_d;
  logic [3:0]    flg_d;

  // norm holds the bits below the leading one of the significand product
  assign norm     = s1_prod[P-1] ? s1_prod[P-2:0] : {s1_prod[P-3:0], 1'b0};
  assign frac_n   = norm[P-2:F+1];
  assign guard    = norm[F];
  assign sticky   = |norm[F-1:0];
  assign round_up = guard && (sticky || frac_n[0]);
  // A carry out of frac_r leaves frac_r[F-1:0] == 0, so only the exponent moves.
  assign frac_r   = {1'b0, frac_n} + (F + 1)'(round_up);
  assign exp_f    = s1_exp + XW'(s1_prod[P-1]) + XW'(frac_r[F]);
  assign ovf      = !exp_f[XW-1] && (exp_f >= EXP_MAX);
  assign udf      = exp_f[XW-1] || (exp_f == '0);

  always_comb begin
    res_d = {s1_sign, exp_f[E-1:0], frac_r[F-1:0]};
    flg_d = {3'b000, guard || sticky};
    if (s1_spec) begin
      res_d = s1_spec_res;
      flg_d = {s1_spec_inv, 3'b000};
    end else if (ovf) begin
      res_d = {s1_sign, {E{1'b1}}, {F{1'b0}}};
      flg_d = 4'b0101;
    end else if (udf) begin
      res_d = {s1_sign, {(W - 1){1'b0}}};
      flg_d = 4'b0011;
    end
  end

  // Stage 2..STAGES: result/flag registers; stage STAGES drives the outputs.
  logic [STAGES:1] vld;
  logic [W-1:0]    res_q [2:STAGES];
  logic [3:0]      flg_q [2:STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld         <= '0;
      s1_sign     <= 1'b0;
      s1_spec     <= 1'b0;
      s1_spec_inv <= 1'b0;
      s1_spec_res <= '0;
      s1_exp      <= '0;
      s1_prod     <= '0;
      for (int k = 2; k <= STAGES; k++) begin
        res_q[k] <= '0;
        flg_q[k] <= '0;
      end
    end else if (en) begin
      // in_ready == en here, so in_valid alone marks an accepted item
      vld         <= {vld[STAGES-1:1], bus.in_valid};
      s1_sign     <= sign_d;
      s1_spec     <= spec_d;
      s1_spec_inv <= spec_inv_d;
      s1_spec_res <= spec_res_d;
      s1_exp      <= exp_d;
      s1_prod     <= prod_d;
      res_q[2]    <= res_d;
      flg_q[2]    <= flg_d;
      for (int k = 3; k <= STAGES; k++) begin
        res_q[k] <= res_q[k-1];
        flg_q[k] <= flg_q[k-1];
      end
    end
  end

  assign out_v        = vld[STAGES];
  assign en           = bus.out_ready || !out_v;
  assign bus.in_ready = en;
  assign bus.out_valid = out_v;
  assign bus.result    = res_q[STAGES];
  assign bus.flags     = flg_q[STAGES];
endmodule
